wb_regfile: RTL and testbench

Writeback-stage consumer of the MEM/WB pipeline register outputs. It selects the writeback value and destination, writes the 32x32 general register file, and serves two ID-stage read ports with same-cycle write-through bypass. It also keeps a retired-instruction counter and a last-write record for debug. The block sits between the MEM/WB register and the ID stage.

---
 rtl/wb_regfile.sv | 84 ++++++++
 tb/tb_wb_regfile.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/wb_regfile.sv
// Writeback stage: selects the writeback value and destination, updates the 32x32
// register file, and serves two ID read ports with same-cycle write-through bypass.
module wb_regfile #(
  parameter logic [31:0] NOP      = 32'h0000_0020,
  parameter int unsigned LINK_REG = 31,
  parameter int unsigned PC_W     = 9
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            WB_memtoreg,
  input  logic            WB_regwrite,
  input  logic            WB_regdst,
  input  logic            WB_link,
  input  logic [31:0]     WB_data,
  input  logic [31:0]     WB_memdata,
  input  logic [PC_W-1:0] WB_pc_4,
  input  logic [31:0]     WB_inst,
  input  logic [4:0]      ID_rs_addr,
  input  logic [4:0]      ID_rt_addr,
  output logic [31:0]     ID_rs_data,
  output logic [31:0]     ID_rt_data,
  output logic [31:0]     retire_cnt,
  output logic [4:0]      last_wr_addr,
  output logic [31:0]     last_wr_data
);

  localparam logic [4:0] LINK_ADDR = 5'(LINK_REG);

  logic [31:0] regs_q [32];
  logic [31:0] retire_cnt_q, retire_cnt_d;
  logic [4:0]  last_wr_addr_q;
  logic [31:0] last_wr_data_q;

  logic [4:0]  wa;
  logic [31:0] wv;
  logic        we;

  // Link writes override both the destination select and the value select.
  always_comb begin
    wa = WB_regdst ? WB_inst[15:11] : WB_inst[20:16];
    wv = WB_memtoreg ? WB_memdata : WB_data;
    if (WB_link) begin
      wa = LINK_ADDR;
      wv = {{(32-PC_W){1'b0}}, WB_pc_4};
    end
    we = WB_regwrite && (wa != 5'd0);
  end

  assign retire_cnt_d = (WB_inst != NOP) ? retire_cnt_q + 32'd1 : retire_cnt_q;

  // NOTE: the array is cleared on reset so contents are never X; this makes it a
  // flop array rather than a RAM macro, which is acceptable at 32x32.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) regs_q[i] <= '0;
      retire_cnt_q   <= '0;
      last_wr_addr_q <= '0;
      last_wr_data_q <= '0;
    end else begin
      retire_cnt_q <= retire_cnt_d;
      if (we) begin
        regs_q[wa]     <= wv;
        last_wr_addr_q <= wa;
        last_wr_data_q <= wv;
      end
    end
  end

  // Bypass applies whenever a write is committing, independent of rst.
  always_comb begin
    ID_rs_data = regs_q[ID_rs_addr];
    if (we && ID_rs_addr == wa) ID_rs_data = wv;
    if (ID_rs_addr == 5'd0)     ID_rs_data = '0;

    ID_rt_data = regs_q[ID_rt_addr];
    if (we && ID_rt_addr == wa) ID_rt_data = wv;
    if (ID_rt_addr == 5'd0)     ID_rt_data = '0;
  end

  assign retire_cnt   = retire_cnt_q;
  assign last_wr_addr = last_wr_addr_q;
  assign last_wr_data = last_wr_data_q;

endmodule

// File: tb/tb_wb_regfile.sv
// Self-checking bench for wb_regfile: directed cases followed by randomized traffic
// compared against an array-based architectural model.
module tb_wb_regfile;

  localparam logic [31:0] NOP = 32'h0000_0020;

  logic        clk = 1'b0;
  logic        rst;
  logic        WB_memtoreg, WB_regwrite, WB_regdst, WB_link;
  logic [31:0] WB_data, WB_memdata, WB_inst;
  logic [8:0]  WB_pc_4;
  logic [4:0]  ID_rs_addr, ID_rt_addr;
  logic [31:0] ID_rs_data, ID_rt_data, retire_cnt, last_wr_data;
  logic [4:0]  last_wr_addr;

  wb_regfile #(.NOP(NOP), .LINK_REG(31), .PC_W(9)) dut (
    .clk          (clk),
    .rst          (rst),
    .WB_memtoreg  (WB_memtoreg),
    .WB_regwrite  (WB_regwrite),
    .WB_regdst    (WB_regdst),
    .WB_link      (WB_link),
    .WB_data      (WB_data),
    .WB_memdata   (WB_memdata),
    .WB_pc_4      (WB_pc_4),
    .WB_inst      (WB_inst),
    .ID_rs_addr   (ID_rs_addr),
    .ID_rt_addr   (ID_rt_addr),
    .ID_rs_data   (ID_rs_data),
    .ID_rt_data   (ID_rt_data),
    .retire_cnt   (retire_cnt),
    .last_wr_addr (last_wr_addr),
    .last_wr_data (last_wr_data)
  );

  always #5 clk = ~clk;

  // Architectural model state.
  logic [31:0] mdl_reg [32];
  logic [31:0] mdl_cnt;
  logic [4:0]  mdl_lwa;
  logic [31:0] mdl_lwd;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%08h expected=%08h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [4:0] exp_wa();
    if (WB_link) return 5'd31;
    return WB_regdst ? WB_inst[15:11] : WB_inst[20:16];
  endfunction

  function automatic logic [31:0] exp_wv();
    if (WB_link) return {23'd0, WB_pc_4};
    return WB_memtoreg ? WB_memdata : WB_data;
  endfunction

  function automatic logic exp_we();
    return WB_regwrite && (exp_wa() != 5'd0);
  endfunction

  function automatic logic [31:0] exp_read(input logic [4:0] a);
    if (a == 5'd0) return 32'd0;
    if (exp_we() && a == exp_wa()) return exp_wv();
    return mdl_reg[a];
  endfunction

  // Apply what the DUT sampled at the rising edge to the model.
  task automatic model_update();
    if (rst) begin
      for (int i = 0; i < 32; i++) mdl_reg[i] = 32'd0;
      mdl_cnt = 32'd0;
      mdl_lwa = 5'd0;
      mdl_lwd = 32'd0;
    end else begin
      if (WB_inst != NOP) mdl_cnt = mdl_cnt + 32'd1;
      if (exp_we()) begin
        mdl_reg[exp_wa()] = exp_wv();
        mdl_lwa = exp_wa();
        mdl_lwd = exp_wv();
      end
    end
  endtask

  task automatic drive(input logic r, input logic link, input logic rw, input logic rdst,
                       input logic m2r, input logic [31:0] inst, input logic [31:0] data,
                       input logic [31:0] mdata, input logic [8:0] pc4,
                       input logic [4:0] rs, input logic [4:0] rt);
    rst = r; WB_link = link; WB_regwrite = rw; WB_regdst = rdst; WB_memtoreg = m2r;
    WB_inst = inst; WB_data = data; WB_memdata = mdata; WB_pc_4 = pc4;
    ID_rs_addr = rs; ID_rt_addr = rt;
  endtask

  // Inputs are applied after the falling edge; reads checked before and after the rising edge.
  task automatic step();
    #1;
    check("rs_pre", ID_rs_data, exp_read(ID_rs_addr));
    check("rt_pre", ID_rt_data, exp_read(ID_rt_addr));
    @(posedge clk);
    model_update();
    #1;
    check("rs_post", ID_rs_data, exp_read(ID_rs_addr));
    check("rt_post", ID_rt_data, exp_read(ID_rt_addr));
    check("retire_cnt", retire_cnt, mdl_cnt);
    check("last_wr_addr", {27'd0, last_wr_addr}, {27'd0, mdl_lwa});
    check("last_wr_data", last_wr_data, mdl_lwd);
    @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) mdl_reg[i] = 32'd0;
    mdl_cnt = 32'd0; mdl_lwa = 5'd0; mdl_lwd = 32'd0;

    // Reset, then sweep every address on both ports.
    drive(1, 0, 0, 0, 0, NOP, 0, 0, 0, 0, 0);
    @(negedge clk);
    step();
    drive(0, 0, 0, 0, 0, NOP, 0, 0, 0, 0, 0);
    for (int i = 0; i < 32; i++) begin
      ID_rs_addr = 5'(i);
      ID_rt_addr = 5'(31 - i);
      #1;
      check("rst_rs", ID_rs_data, 32'd0);
      check("rst_rt", ID_rt_data, 32'd0);
    end
    check("rst_cnt", retire_cnt, 32'd0);
    check("rst_lwa", {27'd0, last_wr_addr}, 32'd0);
    check("rst_lwd", last_wr_data, 32'd0);

    // R-type write to $5 with bypass visible before the edge.
    drive(0, 0, 1, 1, 0, 32'h0000_2821, 32'hDEAD_BEEF, 32'h0, 9'h0, 5'd5, 5'd0);
    #1 check("rtype_bypass", ID_rs_data, 32'hDEAD_BEEF);
    step();
    drive(0, 0, 0, 1, 0, NOP, 32'h0, 32'h0, 9'h0, 5'd5, 5'd0);
    #1 check("rtype_array", ID_rs_data, 32'hDEAD_BEEF);
    check("rtype_lwa", {27'd0, last_wr_addr}, 32'd5);
    check("rtype_cnt", retire_cnt, 32'd1);

    // Load write to $9 selects memdata over ALU data.
    drive(0, 0, 1, 0, 1, 32'h8C09_0000, 32'hFFFF_FFFF, 32'h1234_5678, 9'h0, 5'd9, 5'd5);
    step();
    check("load_reg9", ID_rs_data, 32'h1234_5678);

    // Link write goes to $31 with zero-extended PC+4; rd=3 is ignored.
    drive(0, 1, 1, 1, 0, 32'h0000_1809, 32'hAAAA_AAAA, 32'hBBBB_BBBB, 9'h1A4, 5'd31, 5'd3);
    step();
    drive(0, 0, 0, 0, 0, NOP, 32'h0, 32'h0, 9'h0, 5'd31, 5'd3);
    step();
    check("link_reg31", ID_rs_data, 32'h0000_01A4);
    check("link_reg3", ID_rt_data, 32'd0);
    check("nop_cnt", retire_cnt, 32'd3);

    // Write to $0 is dropped but the instruction still retires.
    drive(0, 0, 1, 1, 0, 32'h0000_0021, 32'hFFFF_FFFF, 32'h0, 9'h0, 5'd0, 5'd0);
    step();
    check("zero_read", ID_rs_data, 32'd0);
    check("zero_lwa", {27'd0, last_wr_addr}, 32'd31);
    check("zero_lwd", last_wr_data, 32'h0000_01A4);
    check("zero_cnt", retire_cnt, 32'd4);

    // Bring the count to 7, then reset concurrently with a write to $4.
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 0, 1, 0, 32'h0000_0021, 32'h0, 32'h0, 9'h0, 5'd31, 5'd4);
      step();
    end
    check("pre_rst_cnt", retire_cnt, 32'd7);
    drive(1, 0, 1, 1, 0, 32'h0000_2021, 32'h0000_0055, 32'h0, 9'h0, 5'd4, 5'd31);
    step();
    drive(0, 0, 0, 0, 0, NOP, 32'h0, 32'h0, 9'h0, 5'd4, 5'd31);
    #1;
    check("midrst_reg4", ID_rs_data, 32'd0);
    check("midrst_reg31", ID_rt_data, 32'd0);
    check("midrst_cnt", retire_cnt, 32'd0);

    // Randomized traffic; rs/rt often aimed at the write destination to hit the bypass.
    for (int n = 0; n < 400; n++) begin
      logic [31:0] inst;
      logic [4:0]  rs, rt;
      inst = ($urandom_range(0, 7) == 0) ? NOP : $urandom();
      rs = 5'($urandom());
      rt = 5'($urandom());
      drive(($urandom_range(0, 49) == 0), ($urandom_range(0, 7) == 0), 1'($urandom()),
            1'($urandom()), 1'($urandom()), inst, $urandom(), $urandom(),
            9'($urandom()), rs, rt);
      if ($urandom_range(0, 2) == 0) ID_rs_addr = exp_wa();
      if ($urandom_range(0, 2) == 0) ID_rt_addr = exp_wa();
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
